// File: rtl/loader_pkg.sv
// ============================================================================
// Module : loader_pkg
// Shared state encoding and framing constants for the instruction loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_WIDTH      = 16;

endpackage

`default_nettype wire

// File: rtl/instr_loader_byte_assembler.sv
// ============================================================================
// Module : byte_assembler
// Packs a byte stream into little-endian words, byte k into bits [8k+7:8k].
// Rev    : 1.0
// ============================================================================
`default_nettype none

module byte_assembler
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  byte_stb,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  last_byte
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_stb) begin
      cnt_d = cnt_q + 2'd1;
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (cnt_q == 2'(k)) word_d[8*k +: 8] = byte_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // Exposes the word including this cycle's byte so the final byte is captured on the same edge.
  assign word      = word_d;
  assign last_byte = (cnt_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// Module : instr_loader
// Receives a length-prefixed byte image, writes it into instruction memory
// word by word, and holds the core in reset until the image is complete.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_loader
  import loader_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          MEM_ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [LEN_WIDTH:0] MEM_DEPTH = {{LEN_WIDTH{1'b0}}, 1'b1} << MEM_ADDR_WIDTH;

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [MEM_ADDR_WIDTH:0] word_idx_q, word_idx_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   asm_word;
  logic                    asm_last;
  logic                    asm_clr;
  logic                    xfer;
  logic [LEN_WIDTH:0]      n_full;

  assign xfer   = in_valid && in_ready;
  assign n_full = {1'b0, in_data, len_q[7:0]};

  byte_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (asm_clr),
    .byte_stb (xfer && (state_q == DATA)),
    .byte_in  (in_data),
    .word     (asm_word),
    .last_byte(asm_last)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_clr    = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN_LO;
      end
      LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = in_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = in_data;
          if (n_full == '0) begin
            state_d = DONE;
          end else if (n_full > MEM_DEPTH) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            word_idx_d = '0;
            asm_clr    = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer && asm_last) begin
          state_d = WRITE;
          addr_d  = BASE_ADDR + (DATA_WIDTH'(word_idx_q) << 2);
          wdata_d = asm_word;
        end
      end
      WRITE: begin
        // word_idx carries one extra bit, so a full-depth image compares without wrapping.
        if (LEN_WIDTH'(word_idx_q) == len_q - 1'b1) begin
          state_d = DONE;
        end else begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
  assign mem_we    = (state_q == WRITE);
  assign busy      = in_ready || mem_we;
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign cpu_rst   = (state_q != DONE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// Module : tb_instr_loader
// Self-checking bench for instr_loader: vector table plus directed sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  instr_loader #(
    .DATA_WIDTH    (32),
    .MEM_ADDR_WIDTH(8),
    .BASE_ADDR     (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic        bsy;
    logic        dn;
    logic        er;
    logic        crst;
    logic [31:0] addr;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int   passed = 0;
  int   total  = 0;
  int   ready_bad = 0;
  wr_t  wr_q[$];
  vec_t tbl[14];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Write capture and in_ready legality, sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) wr_q.push_back('{mem_addr, mem_wdata});
    if (rst === 1'b0 && in_ready !== (busy && !mem_we)) ready_bad++;
  end

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gap, input logic st);
    int n;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic load(input logic [7:0] bq[$], input int gap);
    foreach (bq[i]) drive_byte(bq[i], gap, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] bq[$];
    logic [7:0] b0, b1, b2, b3;
    int         errs;

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    apply_reset();

    // ---- basic load: table of {inputs, expected outputs} per cycle ----
    //            st vld data   rdy we bsy dn er crst addr          wdata
    tbl[0]  = '{1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0, 32'h0};
    tbl[1]  = '{1'b0,1'b1,8'h02, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h0};
    tbl[2]  = '{1'b0,1'b1,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h0};
    tbl[3]  = '{1'b0,1'b1,8'h93, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h0};
    tbl[4]  = '{1'b0,1'b1,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h0};
    tbl[5]  = '{1'b0,1'b1,8'h50, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h0};
    tbl[6]  = '{1'b0,1'b1,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h0};
    tbl[7]  = '{1'b0,1'b1,8'h13, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h00500093};
    tbl[8]  = '{1'b0,1'b1,8'h13, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h00500093};
    tbl[9]  = '{1'b0,1'b1,8'h01, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h00500093};
    tbl[10] = '{1'b0,1'b1,8'ha0, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h00500093};
    tbl[11] = '{1'b0,1'b1,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0, 32'h00500093};
    tbl[12] = '{1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 32'h4, 32'h00a00113};
    tbl[13] = '{1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 32'h4, 32'h00a00113};

    for (int i = 0; i < 14; i++) begin
      start    = tbl[i].st;
      in_valid = tbl[i].vld;
      in_data  = tbl[i].d;
      check($sformatf("basic_row%0d", i),
            96'({in_ready, mem_we, busy, done, err, cpu_rst, mem_addr, mem_wdata}),
            96'({tbl[i].rdy, tbl[i].we, tbl[i].bsy, tbl[i].dn, tbl[i].er, tbl[i].crst,
                 tbl[i].addr, tbl[i].wd}));
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;

    // ---- backpressure: same image, 3 idle cycles before every byte ----
    wr_q.delete();
    do_start();
    check("start_from_done_clears_done", 96'({done, cpu_rst}), 96'(2'b01));
    bq = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'ha0, 8'h00};
    load(bq, 3);
    @(negedge clk);
    check("bp_write_count", 96'(wr_q.size()), 96'(2));
    if (wr_q.size() == 2) begin
      check("bp_write0", {32'h0, wr_q[0].a, wr_q[0].d}, {32'h0, 32'h0, 32'h00500093});
      check("bp_write1", {32'h0, wr_q[1].a, wr_q[1].d}, {32'h0, 32'h4, 32'h00a00113});
    end
    check("bp_done", 96'({done, cpu_rst, busy}), 96'(3'b100));
    check("bp_ready_only_in_load_states", 96'(ready_bad), 96'(0));

    // ---- zero length ----
    wr_q.delete();
    do_start();
    bq = '{8'h00, 8'h00};
    load(bq, 0);
    check("zero_done", 96'({done, cpu_rst, busy, err}), 96'(4'b1000));
    check("zero_no_write", 96'(wr_q.size()), 96'(0));

    // ---- overflow: N = 257 ----
    wr_q.delete();
    do_start();
    bq = '{8'h01, 8'h01};
    load(bq, 0);
    in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    check("ovf_err_state", 96'({err, cpu_rst, in_ready, busy, done}), 96'(5'b11000));
    @(negedge clk);
    in_valid = 1'b0;
    check("ovf_no_write", 96'(wr_q.size()), 96'(0));
    do_start();
    check("ovf_restart", 96'({err, in_ready, busy, cpu_rst}), 96'(4'b0111));
    bq = '{8'h00, 8'h00};
    load(bq, 0);

    // ---- full depth: N = 256 fills memory exactly ----
    wr_q.delete();
    do_start();
    bq = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      bq.push_back(8'(i));
      bq.push_back(~8'(i));
      bq.push_back(8'ha5);
      bq.push_back(8'(i) ^ 8'h3c);
    end
    load(bq, 0);
    @(negedge clk);
    check("full_write_count", 96'(wr_q.size()), 96'(256));
    errs = 0;
    for (int i = 0; i < wr_q.size() && i < 256; i++) begin
      b0 = 8'(i); b1 = ~8'(i); b2 = 8'ha5; b3 = 8'(i) ^ 8'h3c;
      if (wr_q[i].a !== 32'(4 * i) || wr_q[i].d !== {b3, b2, b1, b0}) errs++;
    end
    check("full_write_contents", 96'(errs), 96'(0));
    check("full_done", 96'({done, cpu_rst, err}), 96'(3'b100));

    // ---- reset mid-load ----
    wr_q.delete();
    do_start();
    bq = '{8'h01, 8'h00, 8'h11, 8'h22};
    load(bq, 0);
    rst = 1'b1;
    #1;
    check("midrst_async", 96'({busy, cpu_rst, in_ready, mem_we, done, err}), 96'(6'b010000));
    check("midrst_regs_cleared", {32'h0, mem_addr, mem_wdata}, 96'h0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_no_write", 96'(wr_q.size()), 96'(0));
    do_start();
    bq = '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    load(bq, 0);
    @(negedge clk);
    check("midrst_fresh_write_count", 96'(wr_q.size()), 96'(1));
    if (wr_q.size() == 1)
      check("midrst_fresh_write", {32'h0, wr_q[0].a, wr_q[0].d}, {32'h0, 32'h0, 32'h11223344});

    // ---- start ignored while busy ----
    wr_q.delete();
    do_start();
    bq = '{8'h02, 8'h00, 8'hef};
    load(bq, 0);
    drive_byte(8'hbe, 0, 1'b1);
    bq = '{8'had, 8'hde};
    load(bq, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bq = '{8'h78, 8'h56, 8'h34, 8'h12};
    load(bq, 0);
    @(negedge clk);
    check("busy_start_write_count", 96'(wr_q.size()), 96'(2));
    if (wr_q.size() == 2) begin
      check("busy_start_write0", {32'h0, wr_q[0].a, wr_q[0].d}, {32'h0, 32'h0, 32'hdeadbeef});
      check("busy_start_write1", {32'h0, wr_q[1].a, wr_q[1].d}, {32'h0, 32'h4, 32'h12345678});
    end
    check("busy_start_done", 96'({done, cpu_rst}), 96'(2'b10));
    do_start();
    check("start_in_done", 96'({done, cpu_rst, busy, in_ready}), 96'(4'b0111));
    check("final_ready_legality", 96'(ready_bad), 96'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream and writes it, word by word, into instruction memory.
- Holds the CPU core in reset while loading and releases it once the image has been written.
- Sits between the host/UART byte source and the instrmem write port. The core reads the same memory through its existing PC-addressed read port.

Parameters:
- DATA_WIDTH, 32, instruction word width. Fixed to 4 bytes per word; other values are not supported.
- MEM_ADDR_WIDTH, 8, word-address width of instruction memory. Depth is 2**MEM_ADDR_WIDTH words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written. Must be 4-byte aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load. Sampled only in IDLE, DONE or ERR.
- in_valid  input  1  byte source has valid data.
- in_data  input  8  byte payload.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  DATA_WIDTH  byte address of the write.
- mem_wdata  output  DATA_WIDTH  assembled little-endian word.
- cpu_rst  output  1  active-high reset to the core (pc/regfile).
- busy  output  1  high in LEN_LO, LEN_HI, DATA, WRITE.
- done  output  1  image fully written, core released.
- err  output  1  length exceeded memory depth.

Behaviour:
- Reset (asynchronous, rst=1) forces:
  - state=IDLE;
  - cpu_rst=1, and all other outputs 0;
  - byte counter, word index, length register and word register cleared.
- A byte is transferred when in_valid && in_ready on a rising clk edge. in_ready is a function of state only: 1 in LEN_LO, LEN_HI and DATA; 0 elsewhere.
- Frame format: 16-bit word count N (low byte first), followed by N*4 data bytes. Each word is little-endian: byte k goes to bits [8k+7:8k].
- States:
  - IDLE: cpu_rst=1. start goes to LEN_LO.
  - LEN_LO: accept a byte into len[7:0], then go to LEN_HI.
  - LEN_HI: accept a byte into len[15:8]. Then:
    - N==0 goes to DONE;
    - N > 2**MEM_ADDR_WIDTH goes to ERR;
    - otherwise go to DATA with word_idx=0 and byte_cnt=0.
  - DATA: accept bytes and increment byte_cnt (2-bit). The 4th byte (byte_cnt==3) goes to WRITE.
  - WRITE: exactly one cycle with:
    - mem_we=1;
    - mem_addr = BASE_ADDR + 4*word_idx;
    - mem_wdata = assembled word.
    If word_idx==N-1, go to DONE; else increment word_idx and go to DATA.
  - DONE: cpu_rst=0, done=1. start goes to LEN_LO, which clears done and raises cpu_rst on that transition.
  - ERR: err=1, cpu_rst=1, no writes. start goes to LEN_LO and clears err.
- start is ignored while busy=1. A start coinciding with any byte transfer has no effect on that transfer.
- Throughput is 5 cycles per word minimum (4 byte cycles plus 1 write cycle). Gaps in in_valid simply stall the state.
- mem_addr and mem_wdata are held at their last values outside WRITE and are only meaningful when mem_we=1.
- done asserts in the cycle after the WRITE cycle of the last word. For N==0, done asserts in the cycle after LEN_HI.
- N == 2**MEM_ADDR_WIDTH is legal and fills memory exactly. word_idx is MEM_ADDR_WIDTH+1 bits so the comparison with N-1 never wraps.
- Reset mid-load returns to IDLE immediately. Words already written are not undone, and cpu_rst stays 1.
- Bytes presented in IDLE, WRITE, DONE and ERR are not consumed (in_ready=0).

Decomposition:
- Package loader_pkg contains:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR);
  - BYTES_PER_WORD=4;
  - LEN_WIDTH=16.
- Sub-module byte_assembler: 2-bit byte counter plus a 32-bit register. Inputs: a byte strobe and a clear. Outputs: word and last_byte. The top-level FSM, address generation and length checking stay in instr_loader.

Test Plan:
1. Basic load:
   - Stimulus: start; bytes 02 00 | 93 00 50 00 | 13 01 a0 00 with in_valid held high.
   - Response: mem_we pulses twice, at addr 0x0 with 0x00500093 and at addr 0x4 with 0x00a00113. busy stays high throughout. done=1 and cpu_rst=0 one cycle after the second pulse.
2. Backpressure:
   - Stimulus: same image with in_valid low for 3 cycles between every byte.
   - Response: identical writes and data, no extra mem_we pulses, in_ready high only in LEN_LO, LEN_HI and DATA.
3. Zero length:
   - Stimulus: start; bytes 00 00.
   - Response: no mem_we pulse; done=1, cpu_rst=0.
4. Overflow:
   - Stimulus: MEM_ADDR_WIDTH=8; start; bytes 01 01 (N=257).
   - Response: err=1, cpu_rst=1, no mem_we pulse, in_ready=0. A following start returns to LEN_LO with err=0.
5. Reset mid-load:
   - Stimulus: assert rst after the 2nd data byte of word 0.
   - Response: state=IDLE in the same cycle, cpu_rst=1, busy=0, no write. A fresh load after rst deasserts writes from BASE_ADDR with a correctly assembled word.
6. Start ignored while busy:
   - Stimulus: pulse start during DATA.
   - Response: no effect on the load, and all words are written at the expected addresses.
   - Stimulus: start in DONE.
   - Response: done=0 and cpu_rst=1 on the next cycle.
